// File: rtl/shift_pkg.sv
// ---------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the universal shift register and for any controller
// that drives its mode input, so both sides agree on the operation codes.
// Contents: MODE_W (width of the mode field) and the eight MODE_* codes.
// ---------------------------------------------------------------------------
package shift_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD  = 3'b000;
  localparam logic [MODE_W-1:0] MODE_SHL   = 3'b001;
  localparam logic [MODE_W-1:0] MODE_SHR   = 3'b010;
  localparam logic [MODE_W-1:0] MODE_ROL   = 3'b011;
  localparam logic [MODE_W-1:0] MODE_ROR   = 3'b100;
  localparam logic [MODE_W-1:0] MODE_ASR   = 3'b101;
  localparam logic [MODE_W-1:0] MODE_LOAD  = 3'b110;
  localparam logic [MODE_W-1:0] MODE_CLEAR = 3'b111;

endpackage

// File: rtl/universal_shift_register_if.sv
// ---------------------------------------------------------------------------
// universal_shift_register_if
// Bundles the control, data and status signals of the universal shift
// register. clk and reset are not part of the bundle.
//   master : drives en, mode, ser_in_l, ser_in_r, par_in;
//            observes data_out, ser_out_l, ser_out_r, shift_cnt, done
//   slave  : the shift register itself (opposite directions)
// ---------------------------------------------------------------------------
interface universal_shift_register_if #(
  parameter int WIDTH = 8
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic                        en;
  logic [shift_pkg::MODE_W-1:0] mode;
  logic                        ser_in_l;
  logic                        ser_in_r;
  logic [WIDTH-1:0]            par_in;
  logic [WIDTH-1:0]            data_out;
  logic                        ser_out_l;
  logic                        ser_out_r;
  logic [CNT_W-1:0]            shift_cnt;
  logic                        done;

  modport master (
    output en, mode, ser_in_l, ser_in_r, par_in,
    input  data_out, ser_out_l, ser_out_r, shift_cnt, done
  );

  modport slave (
    input  en, mode, ser_in_l, ser_in_r, par_in,
    output data_out, ser_out_l, ser_out_r, shift_cnt, done
  );

endinterface

// File: rtl/shift_sat_counter.sv
// ---------------------------------------------------------------------------
// shift_sat_counter
// Counts shift operations, saturating at WIDTH, and emits a registered
// one-cycle done pulse on the WIDTH-1 -> WIDTH step only.
// Ports:
//   clk   in  1      rising-edge clock
//   reset in  1      asynchronous active-high reset
//   clr   in  1      return count to 0 (wins over inc)
//   inc   in  1      one shift/rotate happened this cycle
//   cnt   out CNT_W  current count
//   done  out 1      pulse in the cycle cnt first reads WIDTH
// ---------------------------------------------------------------------------
module shift_sat_counter #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // done is only raised while stepping out of the last counting value, so
  // once saturated (FULL) further shifts leave it low; clear beats the step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt  <= cnt + 1'b1;
      done <= (cnt == CNT_LAST);
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/universal_shift_register.sv
// ---------------------------------------------------------------------------
// universal_shift_register
// WIDTH-bit register with per-cycle shift, rotate, arithmetic shift, parallel
// load and clear, plus a saturating shift counter and done pulse for use as a
// serializer / deserializer.
// Ports:
//   clk    in   1   rising-edge clock
//   reset  in   1   asynchronous active-high reset (register -> RESET_VAL)
//   bus    slave    en, mode, ser_in_l, ser_in_r, par_in in;
//                   data_out, ser_out_l, ser_out_r, shift_cnt, done out
// The interface instance must be built with the same WIDTH.
// ---------------------------------------------------------------------------
module universal_shift_register
  import shift_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  universal_shift_register_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic             cnt_inc;
  logic             cnt_clr;
  logic [CNT_W-1:0] cnt;
  logic             done_pulse;

  // Next-value decode. With en low everything holds, including the counter.
  always_comb begin
    data_d  = data_q;
    cnt_inc = 1'b0;
    cnt_clr = 1'b0;
    if (bus.en) begin
      unique case (bus.mode)
        MODE_SHL: begin
          data_d  = {data_q[WIDTH-2:0], bus.ser_in_l};
          cnt_inc = 1'b1;
        end
        MODE_SHR: begin
          data_d  = {bus.ser_in_r, data_q[WIDTH-1:1]};
          cnt_inc = 1'b1;
        end
        MODE_ROL: begin
          data_d  = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
          cnt_inc = 1'b1;
        end
        MODE_ROR: begin
          data_d  = {data_q[0], data_q[WIDTH-1:1]};
          cnt_inc = 1'b1;
        end
        MODE_ASR: begin
          data_d  = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
          cnt_inc = 1'b1;
        end
        MODE_LOAD: begin
          data_d  = bus.par_in;
          cnt_clr = 1'b1;
        end
        MODE_CLEAR: begin
          data_d  = RESET_VAL;
          cnt_clr = 1'b1;
        end
        default: begin
          data_d = data_q;
        end
      endcase
    end
  end

  // Data register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= RESET_VAL;
    end else begin
      data_q <= data_d;
    end
  end

  shift_sat_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .cnt   (cnt),
    .done  (done_pulse)
  );

  // Serial outputs come straight from the register ends, no extra latency.
  assign bus.data_out  = data_q;
  assign bus.ser_out_l = data_q[WIDTH-1];
  assign bus.ser_out_r = data_q[0];
  assign bus.shift_cnt = cnt;
  assign bus.done      = done_pulse;

endmodule

// File: tb/tb_universal_shift_register.sv
// ---------------------------------------------------------------------------
// tb_universal_shift_register
// Self-checking bench: a WIDTH=8 instance exercised by a vector table, hand
// sequences and random operations against an arithmetic reference model, and
// a WIDTH=16 / RESET_VAL=0xBEEF instance for the parameter corner.
// ---------------------------------------------------------------------------
module tb_universal_shift_register;
  import shift_pkg::*;

  logic clk = 1'b0;
  logic reset;

  int vec_count  = 0;
  int miss_count = 0;

  universal_shift_register_if #(.WIDTH(8))  bus8 ();
  universal_shift_register_if #(.WIDTH(16)) bus16 ();

  universal_shift_register #(
    .WIDTH     (8),
    .RESET_VAL (8'h00)
  ) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8.slave)
  );

  universal_shift_register #(
    .WIDTH     (16),
    .RESET_VAL (16'hBEEF)
  ) dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus16.slave)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       en;
    logic [2:0] mode;
    logic       sl;
    logic       sr;
    logic [7:0] par;
    logic [7:0] exp_data;
    logic [3:0] exp_cnt;
    logic       exp_done;
  } vec_t;

  vec_t tbl[17];

  // Reference model state for the 8-bit instance.
  int unsigned m_data;
  int unsigned m_cnt;
  int unsigned m_done;

  // Compare one value and record the outcome.
  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive the 8-bit instance for one clock and settle just after the edge.
  task automatic applyStimulus(input logic en, input logic [2:0] mode,
                               input logic sl, input logic sr,
                               input logic [7:0] par);
    @(negedge clk);
    bus8.en       = en;
    bus8.mode     = mode;
    bus8.ser_in_l = sl;
    bus8.ser_in_r = sr;
    bus8.par_in   = par;
    @(posedge clk);
    #1;
  endtask

  // Same, for the 16-bit instance.
  task automatic apply16(input logic en, input logic [2:0] mode,
                         input logic sr, input logic [15:0] par);
    @(negedge clk);
    bus16.en       = en;
    bus16.mode     = mode;
    bus16.ser_in_l = 1'b0;
    bus16.ser_in_r = sr;
    bus16.par_in   = par;
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour in plain arithmetic on an 8-bit unsigned value.
  task automatic model_step(input logic en, input logic [2:0] mode,
                            input logic sl, input logic sr,
                            input logic [7:0] par);
    int unsigned prev;
    bit          is_shift;
    is_shift = 1'b0;
    m_done   = 0;
    if (en) begin
      case (mode)
        MODE_SHL: begin m_data = (m_data * 2 + sl) % 256;                   is_shift = 1'b1; end
        MODE_SHR: begin m_data = m_data / 2 + sr * 128;                     is_shift = 1'b1; end
        MODE_ROL: begin m_data = (m_data * 2) % 256 + m_data / 128;         is_shift = 1'b1; end
        MODE_ROR: begin m_data = m_data / 2 + (m_data % 2) * 128;           is_shift = 1'b1; end
        MODE_ASR: begin m_data = m_data / 2 + (m_data / 128) * 128;         is_shift = 1'b1; end
        MODE_LOAD:  begin m_data = par; m_cnt = 0; end
        MODE_CLEAR: begin m_data = 0;   m_cnt = 0; end
        default: ;
      endcase
      if (is_shift) begin
        prev  = m_cnt;
        m_cnt = (m_cnt < 8) ? m_cnt + 1 : 8;
        m_done = (prev == 7) ? 1 : 0;
      end
    end
  endtask

  initial begin
    logic [7:0] ser_bits;
    logic [2:0] rmode;
    logic       ren, rsl, rsr;
    logic [7:0] rpar;
    int         pick;

    tbl[0]  = '{"load_a5",   1'b1, MODE_LOAD,  1'b0, 1'b0, 8'hA5, 8'hA5, 4'd0, 1'b0};
    tbl[1]  = '{"shl_in1",   1'b1, MODE_SHL,   1'b1, 1'b0, 8'h00, 8'h4B, 4'd1, 1'b0};
    tbl[2]  = '{"load_a5b",  1'b1, MODE_LOAD,  1'b0, 1'b0, 8'hA5, 8'hA5, 4'd0, 1'b0};
    tbl[3]  = '{"shr_in0",   1'b1, MODE_SHR,   1'b0, 1'b0, 8'h00, 8'h52, 4'd1, 1'b0};
    tbl[4]  = '{"load_81",   1'b1, MODE_LOAD,  1'b0, 1'b0, 8'h81, 8'h81, 4'd0, 1'b0};
    tbl[5]  = '{"rol_81",    1'b1, MODE_ROL,   1'b0, 1'b0, 8'h00, 8'h03, 4'd1, 1'b0};
    tbl[6]  = '{"load_81b",  1'b1, MODE_LOAD,  1'b0, 1'b0, 8'h81, 8'h81, 4'd0, 1'b0};
    tbl[7]  = '{"ror_81",    1'b1, MODE_ROR,   1'b0, 1'b0, 8'h00, 8'hC0, 4'd1, 1'b0};
    tbl[8]  = '{"load_81c",  1'b1, MODE_LOAD,  1'b0, 1'b0, 8'h81, 8'h81, 4'd0, 1'b0};
    tbl[9]  = '{"asr_81",    1'b1, MODE_ASR,   1'b0, 1'b0, 8'h00, 8'hC0, 4'd1, 1'b0};
    tbl[10] = '{"load_40",   1'b1, MODE_LOAD,  1'b0, 1'b0, 8'h40, 8'h40, 4'd0, 1'b0};
    tbl[11] = '{"asr_40",    1'b1, MODE_ASR,   1'b0, 1'b0, 8'h00, 8'h20, 4'd1, 1'b0};
    tbl[12] = '{"en0_shl_1", 1'b0, MODE_SHL,   1'b1, 1'b1, 8'hFF, 8'h20, 4'd1, 1'b0};
    tbl[13] = '{"en0_shl_2", 1'b0, MODE_SHL,   1'b1, 1'b1, 8'hFF, 8'h20, 4'd1, 1'b0};
    tbl[14] = '{"en0_shl_3", 1'b0, MODE_SHL,   1'b1, 1'b1, 8'hFF, 8'h20, 4'd1, 1'b0};
    tbl[15] = '{"hold",      1'b1, MODE_HOLD,  1'b1, 1'b1, 8'hFF, 8'h20, 4'd1, 1'b0};
    tbl[16] = '{"clear",     1'b1, MODE_CLEAR, 1'b0, 1'b0, 8'hFF, 8'h00, 4'd0, 1'b0};

    bus8.en = 1'b0;  bus8.mode = MODE_HOLD;  bus8.ser_in_l = 1'b0;
    bus8.ser_in_r = 1'b0;  bus8.par_in = '0;
    bus16.en = 1'b0; bus16.mode = MODE_HOLD; bus16.ser_in_l = 1'b0;
    bus16.ser_in_r = 1'b0; bus16.par_in = '0;

    // Power-on reset, released between edges.
    reset = 1'b1;
    #12;
    reset = 1'b0;
    checkOutput("rst8_data",  64'(bus8.data_out),   64'h00);
    checkOutput("rst8_cnt",   64'(bus8.shift_cnt),  64'd0);
    checkOutput("rst8_done",  64'(bus8.done),       64'd0);
    checkOutput("rst16_data", 64'(bus16.data_out),  64'hBEEF);
    checkOutput("rst16_cnt",  64'(bus16.shift_cnt), 64'd0);

    // Table-driven vectors.
    for (int i = 0; i < 17; i++) begin
      applyStimulus(tbl[i].en, tbl[i].mode, tbl[i].sl, tbl[i].sr, tbl[i].par);
      checkOutput({tbl[i].name, "_data"}, 64'(bus8.data_out),  64'(tbl[i].exp_data));
      checkOutput({tbl[i].name, "_cnt"},  64'(bus8.shift_cnt), 64'(tbl[i].exp_cnt));
      checkOutput({tbl[i].name, "_done"}, 64'(bus8.done),      64'(tbl[i].exp_done));
      checkOutput({tbl[i].name, "_sol"},  64'(bus8.ser_out_l), 64'(tbl[i].exp_data[7]));
      checkOutput({tbl[i].name, "_sor"},  64'(bus8.ser_out_r), 64'(tbl[i].exp_data[0]));
    end

    // Serializer: LOAD 0xC3 then 8 SHL, MSB-first stream sampled before edges.
    ser_bits = 8'b1100_0011;
    applyStimulus(1'b1, MODE_LOAD, 1'b0, 1'b0, 8'hC3);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput($sformatf("ser_bit%0d", i), 64'(bus8.ser_out_l), 64'(ser_bits[7-i]));
      bus8.mode = MODE_SHL;
      bus8.ser_in_l = 1'b0;
      @(posedge clk);
      #1;
      checkOutput($sformatf("ser_cnt%0d", i),  64'(bus8.shift_cnt), 64'(i + 1));
      checkOutput($sformatf("ser_done%0d", i), 64'(bus8.done),      64'(i == 7));
    end
    applyStimulus(1'b1, MODE_SHL, 1'b0, 1'b0, 8'h00);
    checkOutput("ser9_cnt",  64'(bus8.shift_cnt), 64'd8);
    checkOutput("ser9_done", 64'(bus8.done),      64'd0);
    checkOutput("ser9_data", 64'(bus8.data_out),  64'h00);

    // Deserializer word, with CLEAR replacing what would be the 8th shift.
    applyStimulus(1'b1, MODE_CLEAR, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, MODE_SHL, 1'b1, 1'b0, 8'h00);
    checkOutput("pre_clr_cnt",  64'(bus8.shift_cnt), 64'd7);
    checkOutput("pre_clr_data", 64'(bus8.data_out),  64'h7F);
    applyStimulus(1'b1, MODE_CLEAR, 1'b1, 1'b0, 8'h00);
    checkOutput("clr8_cnt",  64'(bus8.shift_cnt), 64'd0);
    checkOutput("clr8_done", 64'(bus8.done),      64'd0);
    checkOutput("clr8_data", 64'(bus8.data_out),  64'h00);

    // Asynchronous reset mid-cycle with register holding 0x5A.
    applyStimulus(1'b1, MODE_LOAD, 1'b0, 1'b0, 8'h2D);
    applyStimulus(1'b1, MODE_SHL,  1'b0, 1'b0, 8'h00);
    checkOutput("pre_rst_data", 64'(bus8.data_out),  64'h5A);
    checkOutput("pre_rst_cnt",  64'(bus8.shift_cnt), 64'd1);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("arst_data", 64'(bus8.data_out),  64'h00);
    checkOutput("arst_cnt",  64'(bus8.shift_cnt), 64'd0);
    checkOutput("arst_done", 64'(bus8.done),      64'd0);
    @(negedge clk);
    bus8.en = 1'b0;
    reset = 1'b0;

    // WIDTH=16: reset value, then LOAD + 16 SHR with ones shifted in.
    checkOutput("w16_rst_data", 64'(bus16.data_out), 64'hBEEF);
    apply16(1'b1, MODE_LOAD, 1'b0, 16'h1234);
    checkOutput("w16_load", 64'(bus16.data_out), 64'h1234);
    for (int i = 0; i < 16; i++) begin
      apply16(1'b1, MODE_SHR, 1'b1, 16'h0000);
      checkOutput($sformatf("w16_done%0d", i), 64'(bus16.done),      64'(i == 15));
      checkOutput($sformatf("w16_cnt%0d", i),  64'(bus16.shift_cnt), 64'(i + 1));
    end
    checkOutput("w16_data", 64'(bus16.data_out), 64'hFFFF);
    apply16(1'b1, MODE_CLEAR, 1'b0, 16'h0000);
    checkOutput("w16_clear", 64'(bus16.data_out), 64'hBEEF);
    apply16(1'b0, MODE_HOLD, 1'b0, 16'h0000);

    // Random operations against the reference model, biased toward shifts
    // so the counter regularly reaches and sits at saturation.
    applyStimulus(1'b1, MODE_CLEAR, 1'b0, 1'b0, 8'h00);
    m_data = 0; m_cnt = 0; m_done = 0;
    for (int i = 0; i < 400; i++) begin
      pick = $urandom_range(0, 19);
      if (pick < 15)       rmode = 3'($urandom_range(1, 5));
      else if (pick == 15) rmode = MODE_HOLD;
      else if (pick == 16) rmode = MODE_LOAD;
      else if (pick == 17) rmode = MODE_CLEAR;
      else                 rmode = 3'($urandom_range(0, 7));
      ren  = ($urandom_range(0, 9) != 0);
      rsl  = 1'($urandom_range(0, 1));
      rsr  = 1'($urandom_range(0, 1));
      rpar = 8'($urandom_range(0, 255));
      applyStimulus(ren, rmode, rsl, rsr, rpar);
      model_step(ren, rmode, rsl, rsr, rpar);
      checkOutput($sformatf("rnd%0d_data", i), 64'(bus8.data_out),  64'(m_data));
      checkOutput($sformatf("rnd%0d_cnt", i),  64'(bus8.shift_cnt), 64'(m_cnt));
      checkOutput($sformatf("rnd%0d_done", i), 64'(bus8.done),      64'(m_done));
      checkOutput($sformatf("rnd%0d_sol", i),  64'(bus8.ser_out_l), 64'(m_data / 128));
      checkOutput($sformatf("rnd%0d_sor", i),  64'(bus8.ser_out_r), 64'(m_data % 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
